emif_input_loader: RTL and testbench

//  Upstream feeder for the activation input buffers. On start, reads a run of wide words from
//  the external-memory interface (EMIF) and unpacks each into narrow lanes. Writes the lanes

---
 rtl/emif_input_loader_if.sv | 48 ++++
 rtl/emif_input_loader.sv | 123 ++++++++++++
 tb/tb_emif_input_loader.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/emif_input_loader_if.sv
`default_nettype none
// ============================================================================
//  Module      : emif_input_loader_if
//  Description : Bundles the control handshake, the EMIF read bus and the
//                input-buffer write port of emif_input_loader.
//                slave  : the loader's own view (it receives start, drives
//                         the EMIF address and the buffer port).
//                master : the surrounding system's view (layer FSM, EMIF
//                         model, buffer bank).
//  Signals     : start, src_base, dst_base, num_words   (request)
//                busy, done                             (status)
//                emif_address, emif_dataout, emif_wen   (EMIF read bus)
//                buf_portaaddr, buf_portadatain,
//                buf_portawe                            (buffer RW port)
//  Revision    : 1.0  initial release
// ============================================================================
interface emif_input_loader_if #(
    parameter int EMIF_ADDR_WIDTH = 14,
    parameter int EMIF_DATA_WIDTH = 128,
    parameter int BUF_ADDR_WIDTH  = 8,
    parameter int BUF_DATA_WIDTH  = 16
);
    logic                       start;
    logic [EMIF_ADDR_WIDTH-1:0] src_base;
    logic [BUF_ADDR_WIDTH-1:0]  dst_base;
    logic [EMIF_ADDR_WIDTH:0]   num_words;
    logic                       busy;
    logic                       done;
    logic [EMIF_ADDR_WIDTH-1:0] emif_address;
    logic [EMIF_DATA_WIDTH-1:0] emif_dataout;
    logic                       emif_wen;
    logic [BUF_ADDR_WIDTH-1:0]  buf_portaaddr;
    logic [BUF_DATA_WIDTH-1:0]  buf_portadatain;
    logic                       buf_portawe;

    modport master (
        output start, src_base, dst_base, num_words, emif_dataout,
        input  busy, done, emif_address, emif_wen,
               buf_portaaddr, buf_portadatain, buf_portawe
    );

    modport slave (
        input  start, src_base, dst_base, num_words, emif_dataout,
        output busy, done, emif_address, emif_wen,
               buf_portaaddr, buf_portadatain, buf_portawe
    );
endinterface
`default_nettype wire

// File: rtl/emif_input_loader.sv
`default_nettype none
// ============================================================================
//  Module      : emif_input_loader
//  Description : On start, reads num_words wide words from the EMIF starting
//                at src_base, splits each into LANES narrow lanes (lane 0 =
//                LSBs) and writes them one per cycle into the input buffer
//                starting at dst_base. Both addresses wrap silently.
//  Ports       : clk   - single clock, all state on posedge
//                reset - asynchronous active-low reset
//                bus   - emif_input_loader_if.slave (request, status,
//                        EMIF read bus, buffer write port)
//  Revision    : 1.0  initial release
// ============================================================================
module emif_input_loader #(
    parameter int EMIF_ADDR_WIDTH = 14,
    parameter int EMIF_DATA_WIDTH = 128,
    parameter int BUF_ADDR_WIDTH  = 8,
    parameter int BUF_DATA_WIDTH  = 16
) (
    input  wire logic            clk,
    input  wire logic            reset,
    emif_input_loader_if.slave   bus
);
    localparam int c_LANES  = EMIF_DATA_WIDTH / BUF_DATA_WIDTH;
    localparam int c_LANE_W = (c_LANES > 1) ? $clog2(c_LANES) : 1;
    localparam logic [c_LANE_W-1:0] c_LAST_LANE = c_LANE_W'(c_LANES - 1);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_FETCH  = 2'd1;
    localparam logic [1:0] c_UNPACK = 2'd2;
    localparam logic [1:0] c_FIN    = 2'd3;

    logic [1:0]                 r_state;
    logic [BUF_ADDR_WIDTH-1:0]  r_dst;
    logic [EMIF_ADDR_WIDTH:0]   r_words_left;
    logic [c_LANE_W-1:0]        r_lane;
    // Holds the lanes of the current word not yet written; shifted right
    // by one lane per write so the next lane is always in the LSBs.
    logic [EMIF_DATA_WIDTH-1:0] r_word;

    // The loader only ever reads the EMIF.
    assign bus.emif_wen = 1'b0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state             <= c_IDLE;
            r_dst               <= '0;
            r_words_left        <= '0;
            r_lane              <= '0;
            r_word              <= '0;
            bus.busy            <= 1'b0;
            bus.done            <= 1'b0;
            bus.emif_address    <= '0;
            bus.buf_portaaddr   <= '0;
            bus.buf_portadatain <= '0;
            bus.buf_portawe     <= 1'b0;
        end else begin
            // done and the write strobe are single-cycle unless re-asserted.
            bus.done        <= 1'b0;
            bus.buf_portawe <= 1'b0;

            case (r_state)
                c_IDLE: begin
                    if (bus.start) begin
                        r_dst            <= bus.dst_base;
                        r_words_left     <= bus.num_words;
                        // emif_address doubles as the source pointer, so the
                        // first word is already addressed during FETCH.
                        bus.emif_address <= bus.src_base;
                        if (bus.num_words == '0) begin
                            r_state  <= c_FIN;
                            bus.done <= 1'b1;
                        end else begin
                            r_state  <= c_FETCH;
                            bus.busy <= 1'b1;
                        end
                    end
                end

                c_FETCH: begin
                    // Lane 0 goes straight to the port; the rest are parked.
                    r_word              <= bus.emif_dataout >> BUF_DATA_WIDTH;
                    bus.buf_portadatain <= bus.emif_dataout[BUF_DATA_WIDTH-1:0];
                    bus.buf_portawe     <= 1'b1;
                    bus.buf_portaaddr   <= r_dst;
                    r_dst               <= r_dst + BUF_ADDR_WIDTH'(1);
                    bus.emif_address    <= bus.emif_address + EMIF_ADDR_WIDTH'(1);
                    r_lane              <= '0;
                    r_state             <= c_UNPACK;
                end

                c_UNPACK: begin
                    if (r_lane == c_LAST_LANE) begin
                        if (r_words_left == (EMIF_ADDR_WIDTH+1)'(1)) begin
                            r_state  <= c_FIN;
                            bus.busy <= 1'b0;
                            bus.done <= 1'b1;
                        end else begin
                            r_state <= c_FETCH;
                        end
                        r_words_left <= r_words_left - (EMIF_ADDR_WIDTH+1)'(1);
                    end else begin
                        r_lane              <= r_lane + c_LANE_W'(1);
                        bus.buf_portadatain <= r_word[BUF_DATA_WIDTH-1:0];
                        r_word              <= r_word >> BUF_DATA_WIDTH;
                        bus.buf_portawe     <= 1'b1;
                        bus.buf_portaaddr   <= r_dst;
                        r_dst               <= r_dst + BUF_ADDR_WIDTH'(1);
                    end
                end

                c_FIN: begin
                    r_state <= c_IDLE;
                end

                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_emif_input_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_emif_input_loader
//  Description : Self-checking bench for emif_input_loader. Models the EMIF
//                as a combinational memory and the input buffer as a memory
//                written on the write strobe; compares transfers against
//                expected lane placement, write counts and done timing.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_emif_input_loader;
    localparam int EAW = 14;
    localparam int EDW = 128;
    localparam int BAW = 8;
    localparam int BDW = 16;
    localparam int LANES = EDW / BDW;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    emif_input_loader_if #(.EMIF_ADDR_WIDTH(EAW), .EMIF_DATA_WIDTH(EDW),
                           .BUF_ADDR_WIDTH(BAW), .BUF_DATA_WIDTH(BDW)) u_if ();

    emif_input_loader #(.EMIF_ADDR_WIDTH(EAW), .EMIF_DATA_WIDTH(EDW),
                        .BUF_ADDR_WIDTH(BAW), .BUF_DATA_WIDTH(BDW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if)
    );

    logic [EDW-1:0] emif_mem [0:(1<<EAW)-1];
    logic [BDW-1:0] buf_mem  [0:(1<<BAW)-1];

    assign u_if.emif_dataout = emif_mem[u_if.emif_address];

    int cyc = 0;
    int wr_cnt, done_cnt, busy_cnt, busy_rise, done_cyc;
    bit wen_seen;
    bit prev_busy = 1'b0;
    int total = 0;
    int bad = 0;

    // Observation on the falling edge, away from the active edge.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (u_if.buf_portawe) begin
            buf_mem[u_if.buf_portaaddr] = u_if.buf_portadatain;
            wr_cnt = wr_cnt + 1;
        end
        if (u_if.done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
        if (u_if.busy) busy_cnt = busy_cnt + 1;
        if (u_if.busy && !prev_busy) busy_rise = cyc;
        prev_busy = u_if.busy;
        if (u_if.emif_wen) wen_seen = 1'b1;
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_obs();
        for (int i = 0; i < (1 << BAW); i++) buf_mem[i] = 16'hDEAD;
        wr_cnt = 0; done_cnt = 0; busy_cnt = 0;
        busy_rise = -1; done_cyc = -1; wen_seen = 1'b0;
    endtask

    // Returns the observation-cycle index at which start was raised.
    task automatic launch(input logic [EAW-1:0] src, input logic [BAW-1:0] dst,
                          input logic [EAW:0] n, output int s);
        @(negedge clk); #1;
        s = cyc;
        u_if.start = 1'b1; u_if.src_base = src; u_if.dst_base = dst; u_if.num_words = n;
        @(negedge clk); #1;
        u_if.start = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        for (int k = 0; k < limit && done_cnt == 0; k++) begin
            @(negedge clk); #1;
        end
        repeat (4) @(negedge clk);
        #1;
    endtask

    task automatic check_xfer(input string tag, input logic [EAW-1:0] src,
                              input logic [BAW-1:0] dst, input int n,
                              input int exp_writes, input int exp_lat, input int s);
        int mism;
        logic [EDW-1:0] w;
        logic [EAW-1:0] a;
        logic [BAW-1:0] d;
        mism = 0;
        chk({tag, "_done_pulses"}, done_cnt, 1);
        chk({tag, "_done_latency"}, done_cyc - s, exp_lat);
        chk({tag, "_writes"}, wr_cnt, exp_writes);
        chk({tag, "_busy_cycles"}, busy_cnt, n * (1 + LANES));
        if (n > 0) chk({tag, "_busy_to_done"}, done_cyc - busy_rise, n * (1 + LANES));
        for (int wi = 0; wi < n; wi++) begin
            a = src + EAW'(wi);
            w = emif_mem[a];
            for (int l = 0; l < LANES; l++) begin
                d = dst + BAW'(wi * LANES + l);
                if (buf_mem[d] !== w[l*BDW +: BDW]) mism = mism + 1;
            end
        end
        chk({tag, "_buf_mismatches"}, mism, 0);
        chk({tag, "_wen_seen"}, wen_seen, 0);
        chk({tag, "_busy_end"}, u_if.busy, 0);
    endtask

    typedef struct {
        logic [EAW-1:0] src;
        logic [BAW-1:0] dst;
        int             n;
        int             exp_writes;
        int             exp_lat;
    } vec_t;

    vec_t vecs [4];

    initial begin
        int s;
        int wr_at_abort;

        // Table: latency counts from the cycle start is raised; done is seen
        // 1 + N*(1+LANES) observation cycles later.
        vecs[0] = '{src: 14'd5,      dst: 8'd10, n: 1, exp_writes: 8,  exp_lat: 10};
        vecs[1] = '{src: 14'd0,      dst: 8'd0,  n: 3, exp_writes: 24, exp_lat: 28};
        vecs[2] = '{src: 14'h0100,   dst: 8'd7,  n: 0, exp_writes: 0,  exp_lat: 1};
        vecs[3] = '{src: 14'h3fff,   dst: 8'd40, n: 2, exp_writes: 16, exp_lat: 19};

        for (int i = 0; i < (1 << EAW); i++) emif_mem[i] = '0;
        for (int i = 0; i < 8; i++) emif_mem[i] = {$urandom, $urandom, $urandom, $urandom};
        for (int i = 16'h3ff8; i < (1 << EAW); i++) emif_mem[i] = {$urandom, $urandom, $urandom, $urandom};
        emif_mem[14'h0100] = {$urandom, $urandom, $urandom, $urandom};
        emif_mem[5] = 128'h0007_0006_0005_0004_0003_0002_0001_0000;

        u_if.start = 1'b0; u_if.src_base = '0; u_if.dst_base = '0; u_if.num_words = '0;
        clear_obs();

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_busy", u_if.busy, 0);
        chk("rst_done", u_if.done, 0);
        chk("rst_awe", u_if.buf_portawe, 0);
        chk("rst_wen", u_if.emif_wen, 0);
        chk("rst_emif_addr", u_if.emif_address, 0);
        chk("rst_buf_addr", u_if.buf_portaaddr, 0);
        chk("rst_buf_data", u_if.buf_portadatain, 0);
        reset = 1'b1;

        // Abort mid-UNPACK of the second word
        clear_obs();
        launch(14'd0, 8'd0, 15'd3, s);
        for (int k = 0; k < 100 && wr_cnt < LANES + 2; k++) begin
            @(negedge clk); #1;
        end
        chk("abort_reached", wr_cnt, LANES + 2);
        wr_at_abort = wr_cnt;
        reset = 1'b0;
        #1;
        chk("abort_busy", u_if.busy, 0);
        chk("abort_done", u_if.done, 0);
        chk("abort_awe", u_if.buf_portawe, 0);
        repeat (2) @(negedge clk);
        #1;
        reset = 1'b1;
        repeat (40) @(negedge clk);
        #1;
        chk("abort_no_done", done_cnt, 0);
        chk("abort_no_more_writes", wr_cnt, wr_at_abort);

        // Table-driven transfers
        for (int v = 0; v < 4; v++) begin
            clear_obs();
            launch(vecs[v].src, vecs[v].dst, EAW'(vecs[v].n), s);
            wait_done(200);
            check_xfer($sformatf("vec%0d", v), vecs[v].src, vecs[v].dst, vecs[v].n,
                       vecs[v].exp_writes, vecs[v].exp_lat, s);
            if (v == 0) begin
                chk("vec0_buf10", buf_mem[10], 16'h0000);
                chk("vec0_buf13", buf_mem[13], 16'h0003);
                chk("vec0_buf17", buf_mem[17], 16'h0007);
            end
        end

        // Destination wrap plus a start raised while busy
        clear_obs();
        launch(14'd5, 8'd252, 15'd1, s);
        repeat (2) @(negedge clk);
        #1;
        u_if.start = 1'b1; u_if.src_base = 14'd0; u_if.dst_base = 8'd100; u_if.num_words = 15'd2;
        @(negedge clk); #1;
        u_if.start = 1'b0;
        wait_done(200);
        check_xfer("wrap", 14'd5, 8'd252, 1, 8, 10, s);
        chk("wrap_buf255", buf_mem[255], 16'h0003);
        chk("wrap_buf0", buf_mem[0], 16'h0004);
        chk("wrap_buf3", buf_mem[3], 16'h0007);
        repeat (30) @(negedge clk);
        #1;
        chk("ignored_start_done", done_cnt, 1);
        chk("ignored_start_writes", wr_cnt, 8);
        chk("ignored_buf100", buf_mem[100], 16'hDEAD);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
